// File: rtl/sm_seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyphs {dp,g,f,e,d,c,b,a}
// and the scan sequencing states.
package sm_seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // IDLE holds the display dark until the first frame snapshot exists.
    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_BLANK,
        SCAN_SHOW
    } scan_state_t;

endpackage

// File: rtl/sm_hex2seg.sv
// Combinational hex nibble to active-low 7-segment glyph {g,f,e,d,c,b,a}; dp is handled
// by the caller.
module sm_hex2seg
    import sm_seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF[6:0];
        case (nibble)
            4'h0: glyph = SEG_0[6:0];
            4'h1: glyph = SEG_1[6:0];
            4'h2: glyph = SEG_2[6:0];
            4'h3: glyph = SEG_3[6:0];
            4'h4: glyph = SEG_4[6:0];
            4'h5: glyph = SEG_5[6:0];
            4'h6: glyph = SEG_6[6:0];
            4'h7: glyph = SEG_7[6:0];
            4'h8: glyph = SEG_8[6:0];
            4'h9: glyph = SEG_9[6:0];
            4'hA: glyph = SEG_A[6:0];
            4'hB: glyph = SEG_B[6:0];
            4'hC: glyph = SEG_C[6:0];
            4'hD: glyph = SEG_D[6:0];
            4'hE: glyph = SEG_E[6:0];
            4'hF: glyph = SEG_F[6:0];
            default: glyph = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/sm_seg7_scan.sv
// Multiplexed hex 7-segment scanner with per-frame value snapshot and a dark anti-ghost slot.
// Optional leading-zero blanking when SM_SEG7_LZB_EN is defined.
module sm_seg7_scan
    import sm_seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRESCALE_W-1:0] cnt;
    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   shadow;
    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [3:0]            nibble;
    logic                  dp_sel;
    logic [6:0]            glyph;
    logic [6:0]            glyph_shown;
    logic [7:0]            seg_nxt;
    logic [DIGITS-1:0]     dig_nxt;

    assign tick = (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= IDX_LAST;
            shadow <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
            if (tick) begin
                if (idx == IDX_LAST) begin
                    idx    <= '0;
                    shadow <= value;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The first tick after reset always lands on idx == last, so it is a frame start.
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN_IDLE:  if (tick) state_nxt = SCAN_BLANK;
            SCAN_BLANK: state_nxt = tick ? SCAN_BLANK : SCAN_SHOW;
            SCAN_SHOW:  if (tick) state_nxt = SCAN_BLANK;
            default:    state_nxt = SCAN_IDLE;
        endcase
    end

    always_comb begin
        nibble = '0;
        dp_sel = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble = shadow[4*i +: 4];
                dp_sel = dp[i];
            end
        end
    end

    sm_hex2seg u_hex2seg (
        .nibble (nibble),
        .glyph  (glyph)
    );

`ifdef SM_SEG7_LZB_EN
    logic upper_zero;

    // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx) && (shadow[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        glyph_shown = (upper_zero && (idx != '0)) ? GLYPH_BLANK : glyph;
    end
`else
    assign glyph_shown = glyph;
`endif

    always_comb begin
        seg_nxt = SEG_OFF;
        dig_nxt = '1;
        if (en && (state == SCAN_SHOW)) begin
            seg_nxt = {~dp_sel, glyph_shown};
            dig_nxt = ~(DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_OFF;
            dig_n <= '1;
        end else begin
            seg_n <= seg_nxt;
            dig_n <= dig_nxt;
        end
    end

endmodule

// File: tb/tb_sm_seg7_scan.sv
// Scoreboard bench for sm_seg7_scan (DIGITS=4, PRESCALE_W=4); honours SM_SEG7_LZB_EN.
module tb_sm_seg7_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] exp_q[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    sm_seg7_scan #(
        .DIGITS     (4),
        .PRESCALE_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .value (value),
        .dp    (dp),
        .seg_n (seg_n),
        .dig_n (dig_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] s_act, input logic [7:0] s_exp,
                       input logic [3:0] d_act, input logic [3:0] d_exp);
        n_checks++;
        if (s_act === s_exp && d_act === d_exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: seg_n=%h dig_n=%b, expected seg_n=%h dig_n=%b",
                     name, $time, s_act, d_act, s_exp, d_exp);
        end
    endtask

    // Reference: edge k after reset release samples prescaler k-1; ticks at k = 16m, slot m shows
    // digit (m-1)%4 on edges 16m+2 .. 16m+16, dark on 16m+1; frames start at slots 1,5,9,...
    initial begin : model
        int          k;
        int          m;
        int          d;
        int          nib;
        int          msd;
        logic [15:0] snap;
        logic [7:0]  g;
        logic [7:0]  es;
        logic [3:0]  ed;
        k    = 0;
        snap = '0;
        forever begin
            @(posedge clk);
            es = 8'hFF;
            ed = 4'hF;
            if (!rst_n) begin
                k    = 0;
                snap = '0;
            end else begin
                k++;
                if (en && k >= 18 && (k % 16) != 1) begin
                    m   = (k - 2) / 16;
                    d   = (m - 1) % 4;
                    nib = int'((snap >> (4 * d)) & 16'hF);
                    g   = seg_tab[nib];
`ifdef SM_SEG7_LZB_EN
                    msd = 0;
                    for (int i = 0; i < 4; i++)
                        if (((snap >> (4 * i)) & 16'hF) != 0) msd = i;
                    if (d > msd) g[6:0] = 7'h7F;
`else
                    msd = 0;
`endif
                    es = {~dp[d], g[6:0]};
                    ed = ~(4'b0001 << d);
                end
                if ((k % 16) == 0 && (((k / 16) - 1) % 4) == 0) snap = value;
            end
            exp_q.push_back({es, ed});
        end
    end

    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scan_out", seg_n, e[11:4], dig_n, e[3:0]);
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        en    = 1'b1;
        value = 16'h1234;
        dp    = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_state", seg_n, 8'hFF, dig_n, 4'hF);
        rst_n = 1'b1;

        // Two frames of 1234, then switch to ABCD while digit1 of the next frame is lit.
        repeat (102) @(negedge clk);
        value = 16'hABCD;
        repeat (128) @(negedge clk);
        value = 16'h0007;
        repeat (128) @(negedge clk);
        value = 16'h0000;
        repeat (64) @(negedge clk);
        value = 16'h1234;
        dp    = 4'b0001;
        repeat (128) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (40) @(negedge clk);

        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0)
                value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0)
                dp = 4'($urandom);
            en = ($urandom_range(0, 7) != 0);
        end

        // Asynchronous reset in the middle of a lit digit.
        en    = 1'b1;
        dp    = 4'b0000;
        value = 16'h1234;
        repeat (90) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", seg_n, 8'hFF, dig_n, 4'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
